mem_port_arbiter: RTL and testbench

Sequences the single shared instruction/data memory port between three requesters:
- interrupt/reset vector load (M[0]/M[1] reads),
- data access (LDD/STD/PUSH/POP, CALL/RET stack traffic),
- instruction fetch.

It runs one transaction at a time with fixed memory latency, returns read data, and tells the pipeline when fetch is blocked so the PC controller can stall. It sits between the PC/fetch unit, the memory stage and the memory macro.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer: vector > (starved fetch) > data > fetch,
// one transaction at a time with a fixed memory latency.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          v_req,
  input  logic [AW-1:0] v_addr,
  output logic          v_gnt,
  output logic          v_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          fetch_stall,
  output logic          busy
);

  localparam int             SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [1:0]     LAT_LOAD   = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_WAIT = 2'd2} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_lat;
  logic [SW-1:0] r_starve;
  logic [2:0]    r_cur;    // in-flight owner, one-hot {v,d,f}
  logic [2:0]    r_done;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [2:0]    w_win;
  logic          w_idle, w_acc, w_last;

  assign w_idle = (r_state == S_IDLE);
  assign w_acc  = (r_state == S_ACCESS);
  assign w_last = (r_state == S_WAIT) && (r_lat == 2'd0);

  always_comb begin
    w_win = 3'b000;
    if (w_idle) begin
      if (v_req)                              w_win = 3'b100;
      else if (f_req && r_starve == STARVE_TOP) w_win = 3'b001;
      else if (d_req)                         w_win = 3'b010;
      else if (f_req)                         w_win = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (|w_win) w_next = S_ACCESS;
      S_ACCESS: w_next = S_WAIT;
      S_WAIT:   if (r_lat == 2'd0) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en                = w_acc;
    mem_we                = w_acc & r_we;
    mem_addr              = w_acc ? r_addr  : '0;
    mem_wdata             = w_acc ? r_wdata : '0;
    {v_gnt, d_gnt, f_gnt} = w_acc ? r_cur : 3'b000;
    {v_done, d_done, f_done} = r_done;
    busy                  = !w_idle;
    fetch_stall           = f_req & ~r_done[0];
  end

  assign rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur    <= '0;
      r_done   <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_lat    <= '0;
      r_starve <= '0;
      r_rdata  <= '0;
    end else begin
      if (|w_win) begin
        r_cur   <= w_win;
        r_addr  <= w_win[2] ? v_addr : (w_win[1] ? d_addr : f_addr);
        r_we    <= w_win[1] & d_we;
        r_wdata <= w_win[1] ? d_wdata : '0;
      end
      if (w_acc)                     r_lat <= LAT_LOAD;
      else if (r_lat != 2'd0)        r_lat <= r_lat - 2'd1;
      r_done <= w_last ? r_cur : 3'b000;
      if (w_last && !r_we)           r_rdata <= mem_rdata;
      // vector grants deliberately leave the starvation count alone
      if (w_idle) begin
        if (w_win[0] || !f_req)                      r_starve <= '0;
        else if (w_win[1] && r_starve != STARVE_TOP) r_starve <= r_starve + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (MEM_LAT=1 and MEM_LAT=3) share stimulus; each is compared
// every cycle against a transaction-level model plus directed spot checks.
module tb_mem_port_arbiter;
  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       v_req, d_req, d_we, f_req;
  logic [7:0] v_addr, d_addr, d_wdata, f_addr;

  logic       v_gnt_o[NI], v_done_o[NI], d_gnt_o[NI], d_done_o[NI];
  logic       f_gnt_o[NI], f_done_o[NI], mem_en_o[NI], mem_we_o[NI];
  logic       fetch_stall_o[NI], busy_o[NI];
  logic [7:0] rdata_o[NI], mem_addr_o[NI], mem_wdata_o[NI], mem_rdata_i[NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    return (a == 16) ? 8'hA5 : 8'(a * 37 + 11);
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] mem [256];
    logic       pv [3];
    logic [7:0] pa [3];

    mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(L), .STARVE_MAX(3)) u_dut (
      .clk(clk), .reset(reset),
      .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt_o[g]), .v_done(v_done_o[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_o[g]), .d_done(d_done_o[g]),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt_o[g]), .f_done(f_done_o[g]),
      .rdata(rdata_o[g]), .mem_en(mem_en_o[g]), .mem_we(mem_we_o[g]),
      .mem_addr(mem_addr_o[g]), .mem_wdata(mem_wdata_o[g]), .mem_rdata(mem_rdata_i[g]),
      .fetch_stall(fetch_stall_o[g]), .busy(busy_o[g])
    );

    // Memory macro: data is valid only L cycles after mem_en, junk otherwise.
    initial begin
      for (int a = 0; a < 256; a++) mem[a] = init_val(a);
      for (int k = 0; k < 3; k++) begin pv[k] = 1'b0; pa[k] = 8'h00; end
      mem_rdata_i[g] = 8'h00;
      forever begin
        @(negedge clk);
        mem_rdata_i[g] = pv[L-1] ? mem[pa[L-1]] : 8'($urandom);
        for (int k = 2; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
        pv[0] = mem_en_o[g];
        pa[0] = mem_addr_o[g];
        if (mem_en_o[g] && mem_we_o[g]) mem[mem_addr_o[g]] = mem_wdata_o[g];
      end
    end
  end

  // Reference model: one transaction record per instance, timed by phase
  bit         m_act[NI];
  int         m_ph[NI], m_who[NI], m_done[NI], m_starve[NI];
  logic [7:0] m_addr[NI], m_wd[NI], m_rd[NI];
  bit         m_we[NI];
  logic [7:0] rmem[NI][256];
  string      gs[NI];
  bit         rec = 1'b0;

  function automatic logic [2:0] onehot(input int w);
    return (w == 0) ? 3'b100 : (w == 1) ? 3'b010 : (w == 2) ? 3'b001 : 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic       en;
      logic [2:0] eg, ed, og, od;
      en = m_act[i] && (m_ph[i] == 0);
      eg = en ? onehot(m_who[i]) : 3'b000;
      ed = onehot(m_done[i]);
      og = {v_gnt_o[i], d_gnt_o[i], f_gnt_o[i]};
      od = {v_done_o[i], d_done_o[i], f_done_o[i]};
      chk($sformatf("gnt%0d", i), 32'(og), 32'(eg));
      chk($sformatf("done%0d", i), 32'(od), 32'(ed));
      chk($sformatf("membus%0d", i),
          32'({mem_en_o[i], mem_we_o[i], mem_addr_o[i], mem_wdata_o[i]}),
          32'({en, en & m_we[i], en ? m_addr[i] : 8'h00, en ? m_wd[i] : 8'h00}));
      chk($sformatf("rdata%0d", i), 32'(rdata_o[i]), 32'(m_rd[i]));
      chk($sformatf("busy_stall%0d", i), 32'({busy_o[i], fetch_stall_o[i]}),
          32'({m_act[i], f_req & ~ed[0]}));
      if (rec) begin
        if (og == 3'b100) gs[i] = {gs[i], "V"};
        if (og == 3'b010) gs[i] = {gs[i], "D"};
        if (og == 3'b001) gs[i] = {gs[i], "F"};
      end
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      int w;
      if (reset) begin
        m_act[i] = 0; m_starve[i] = 0; m_rd[i] = 8'h00; m_done[i] = -1;
      end else if (m_act[i]) begin
        m_done[i] = -1;
        if (m_ph[i] == 0 && m_we[i]) rmem[i][m_addr[i]] = m_wd[i];
        if (m_ph[i] == lat(i)) begin
          if (!m_we[i]) m_rd[i] = rmem[i][m_addr[i]];
          m_act[i]  = 0;
          m_done[i] = m_who[i];
        end else m_ph[i]++;
      end else begin
        m_done[i] = -1;
        if (v_req)                           w = 0;
        else if (f_req && m_starve[i] == 3)  w = 2;
        else if (d_req)                      w = 1;
        else if (f_req)                      w = 2;
        else                                 w = -1;
        if (w == 2 || !f_req)             m_starve[i] = 0;
        else if (w == 1 && m_starve[i] < 3) m_starve[i]++;
        if (w >= 0) begin
          m_act[i] = 1; m_ph[i] = 0; m_who[i] = w;
          m_addr[i] = (w == 0) ? v_addr : (w == 1) ? d_addr : f_addr;
          m_we[i]   = (w == 1) && d_we;
          m_wd[i]   = (w == 1) ? d_wdata : 8'h00;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_act[i] = 0; m_ph[i] = 0; m_who[i] = 0; m_done[i] = -1; m_starve[i] = 0;
      m_addr[i] = 0; m_wd[i] = 0; m_rd[i] = 0; m_we[i] = 0; gs[i] = "";
      for (int a = 0; a < 256; a++) rmem[i][a] = init_val(a);
    end
    reset = 1'b1; v_req = 1; d_req = 1; f_req = 1; d_we = 0;
    v_addr = 8'h00; d_addr = 8'h44; d_wdata = 8'h00; f_addr = 8'h01;
    @(posedge clk); #1;
    drain(2);

    // Reset release with every request high: vector goes first
    reset = 1'b0;
    for (int i = 0; i < NI; i++) chk($sformatf("rst_busy%0d", i), 32'(busy_o[i]), 0);
    tick();
    for (int i = 0; i < NI; i++) chk($sformatf("first_vgnt%0d", i), 32'(v_gnt_o[i]), 1);
    v_req = 0; d_req = 0; f_req = 0;
    drain(6);

    // Single fetch
    f_req = 1; f_addr = 8'h10;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("f_gnt%0d", i), 32'(f_gnt_o[i]), 1);
      chk($sformatf("f_maddr%0d", i), 32'(mem_addr_o[i]), 32'h10);
    end
    f_req = 0;
    drain(2);
    chk("f_done0", 32'(f_done_o[0]), 1);
    chk("f_rdata0", 32'(rdata_o[0]), 32'hA5);
    drain(2);
    chk("f_done1", 32'(f_done_o[1]), 1);
    chk("f_rdata1", 32'(rdata_o[1]), 32'hA5);
    drain(3);

    // Data write to the top address leaves rdata untouched
    d_req = 1; d_we = 1; d_addr = 8'hFF; d_wdata = 8'h3C;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("w_we%0d", i), 32'({d_gnt_o[i], mem_we_o[i]}), 32'b11);
      chk($sformatf("w_wdata%0d", i), 32'(mem_wdata_o[i]), 32'h3C);
    end
    d_req = 0; d_we = 0;
    drain(2);
    chk("w_done0", 32'(d_done_o[0]), 1);
    chk("w_rdata0", 32'(rdata_o[0]), 32'hA5);
    drain(2);
    chk("w_done1", 32'(d_done_o[1]), 1);
    chk("w_rdata1", 32'(rdata_o[1]), 32'hA5);
    drain(3);

    // Starvation: data and fetch held high
    d_req = 1; f_req = 1; d_addr = 8'h44; f_addr = 8'h20;
    rec = 1;
    drain(60);
    rec = 0;
    for (int i = 0; i < NI; i++) chk_str($sformatf("starve_order%0d", i), gs[i].substr(0, 7), "DDDFDDDF");
    d_req = 0; f_req = 0;
    drain(8);

    // Vector arrives during a data wait
    for (int i = 0; i < NI; i++) gs[i] = "";
    d_req = 1; f_req = 1; v_addr = 8'h01;
    rec = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 8)  v_req = 1;
      if (c == 12) v_req = 0;
      tick();
    end
    rec = 0;
    chk_str("vec_order0", gs[0].substr(0, 3), "DDDV");
    chk_str("vec_order1", gs[1].substr(0, 3), "DDVD");
    d_req = 0; f_req = 0;
    drain(10);

    // Reset during the wait of a read
    d_req = 1; d_we = 0; d_addr = 8'h20;
    tick();
    d_req = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid_busy%0d", i), 32'(busy_o[i]), 0);
      chk($sformatf("mid_rdata%0d", i), 32'(rdata_o[i]), 0);
      chk($sformatf("mid_done%0d", i), 32'({v_done_o[i], d_done_o[i], f_done_o[i]}), 0);
    end
    f_req = 1; f_addr = 8'h30;
    tick();
    for (int i = 0; i < NI; i++) chk($sformatf("post_fgnt%0d", i), 32'(f_gnt_o[i]), 1);
    f_req = 0;
    drain(6);
    for (int i = 0; i < NI; i++) chk($sformatf("post_rdata%0d", i), 32'(rdata_o[i]), 32'(init_val(8'h30)));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 99) == 0);
      v_req   = ($urandom_range(0, 9) == 0);
      d_req   = $urandom_range(0, 1) != 0;
      f_req   = $urandom_range(0, 2) != 0;
      d_we    = $urandom_range(0, 1) != 0;
      v_addr  = 8'($urandom_range(0, 1));
      d_addr  = 8'($urandom);
      f_addr  = 8'($urandom);
      d_wdata = 8'($urandom);
      tick();
    end
    reset = 0; v_req = 0; d_req = 0; f_req = 0;
    drain(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
